// File: rtl/stream_arbiter_2_1_if.sv
// Interface for stream_arbiter_2_1: two source streams, one merged output stream, and the select.
// slave = arbiter view (sources in, merged stream out); master = the environment around it.
// Data width is set by WIDTH and must match the arbiter's WIDTH.
interface stream_arbiter_2_1_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i0_data;
  logic             i0_last;
  logic             i0_valid;
  logic             i0_ready;
  logic [WIDTH-1:0] i1_data;
  logic             i1_last;
  logic             i1_valid;
  logic             i1_ready;
  logic [WIDTH-1:0] y_data;
  logic             y_last;
  logic             y_valid;
  logic             y_ready;
  logic             s0;

  modport slave (
    input  i0_data, i0_last, i0_valid,
    output i0_ready,
    input  i1_data, i1_last, i1_valid,
    output i1_ready,
    output y_data, y_last, y_valid, s0,
    input  y_ready
  );

  modport master (
    output i0_data, i0_last, i0_valid,
    input  i0_ready,
    output i1_data, i1_last, i1_valid,
    input  i1_ready,
    input  y_data, y_last, y_valid, s0,
    output y_ready
  );
endinterface

// File: rtl/stream_arbiter_2_1.sv
// Purpose: two-source round-robin stream arbiter with a registered output beat and select (s0).
// Latency: 1 cycle from source accept to y_valid; one beat per cycle while y_ready stays high.
// Backpressure: y_ready low with y_valid high drops both source readies. Macro PACKET_LOCK_EN keeps packets contiguous.
module stream_arbiter_2_1 #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  stream_arbiter_2_1_if.slave bus
);

  logic [WIDTH-1:0] r_y_data;
  logic             r_y_last;
  logic             r_y_valid;
  logic             r_s0;
  logic             r_prio;

  logic             w_load;
  logic             w_gnt_vld;
  logic             w_gnt_side;
  logic             w_acc;
  logic             w_acc_last;
  logic [WIDTH-1:0] w_acc_data;
  logic             w_prio_upd;

`ifdef PACKET_LOCK_EN
  logic r_lock;
  logic r_lock_side;
`endif

  // The output register can take a new beat when empty or draining this cycle.
  assign w_load = ~r_y_valid | bus.y_ready;

  // Grant: single valid source wins, both valid use prio; an open packet overrides everything.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_side = 1'b0;
    if (bus.i0_valid && bus.i1_valid) begin
      w_gnt_vld  = 1'b1;
      w_gnt_side = r_prio;
    end else if (bus.i0_valid) begin
      w_gnt_vld  = 1'b1;
      w_gnt_side = 1'b0;
    end else if (bus.i1_valid) begin
      w_gnt_vld  = 1'b1;
      w_gnt_side = 1'b1;
    end
`ifdef PACKET_LOCK_EN
    if (r_lock) begin
      w_gnt_vld  = 1'b1;
      w_gnt_side = r_lock_side;
    end
`endif
  end

  // Readies are held low during reset so no source ever sees an accept then.
  assign bus.i0_ready = ~rst & w_load & w_gnt_vld & ~w_gnt_side;
  assign bus.i1_ready = ~rst & w_load & w_gnt_vld &  w_gnt_side;

  assign w_acc      = (bus.i0_ready & bus.i0_valid) | (bus.i1_ready & bus.i1_valid);
  assign w_acc_data = w_gnt_side ? bus.i1_data : bus.i0_data;
  assign w_acc_last = w_gnt_side ? bus.i1_last : bus.i0_last;

`ifdef PACKET_LOCK_EN
  // Priority only rotates at packet boundaries so packets never interleave.
  assign w_prio_upd = w_acc & w_acc_last;
`else
  assign w_prio_upd = w_acc;
`endif

  // Output beat register: fill on accept, otherwise empty when the downstream takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_data  <= '0;
      r_y_last  <= 1'b0;
      r_s0      <= 1'b0;
      r_y_valid <= 1'b0;
    end else if (w_acc) begin
      r_y_data  <= w_acc_data;
      r_y_last  <= w_acc_last;
      r_s0      <= w_gnt_side;
      r_y_valid <= 1'b1;
    end else if (bus.y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  // Round-robin pointer: favour the side that was not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_prio_upd) begin
      r_prio <= ~w_gnt_side;
    end
  end

`ifdef PACKET_LOCK_EN
  // Packet lock: a non-last beat opens a packet on its side, a last beat closes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock      <= 1'b0;
      r_lock_side <= 1'b0;
    end else if (w_acc) begin
      r_lock      <= ~w_acc_last;
      r_lock_side <= w_gnt_side;
    end
  end
`endif

  assign bus.y_data  = r_y_data;
  assign bus.y_last  = r_y_last;
  assign bus.y_valid = r_y_valid;
  assign bus.s0      = r_s0;

endmodule

// File: tb/tb_stream_arbiter_2_1.sv
// Directed bench for stream_arbiter_2_1: reset, alternation, single source, backpressure,
// packet behaviour (both builds) and same-cycle drain+fill.
// Inputs change 1ns after a rising edge; readies are read on the falling edge.
module tb_stream_arbiter_2_1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  stream_arbiter_2_1_if #(.WIDTH(8)) bus();

  stream_arbiter_2_1 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.i0_data  = 8'h00; bus.i0_last = 1'b1; bus.i0_valid = 1'b0;
    bus.i1_data  = 8'h00; bus.i1_last = 1'b1; bus.i1_valid = 1'b0;
    bus.y_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.i0_valid = 1'b1; bus.i1_valid = 1'b1;
    #12;
    total++; if (bus.y_valid !== 1'b0) begin bad++; $display("FAIL por_y_valid got=%0b exp=0", bus.y_valid); end
    total++; if (bus.y_data !== 8'h00) begin bad++; $display("FAIL por_y_data got=%h exp=00", bus.y_data); end
    total++; if (bus.i0_ready !== 1'b0 || bus.i1_ready !== 1'b0) begin bad++; $display("FAIL por_ready got=%0b%0b exp=00", bus.i0_ready, bus.i1_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i0_data = 8'h5A; bus.i1_data = 8'h6B;
    @(negedge clk);
    total++; if (bus.i0_ready !== 1'b1 || bus.i1_ready !== 1'b0) begin bad++; $display("FAIL rel_ready got=%0b%0b exp=10", bus.i0_ready, bus.i1_ready); end
    @(posedge clk); #1;
    total++; if (bus.y_data !== 8'h5A || bus.s0 !== 1'b0) begin bad++; $display("FAIL rel_first got=%h/%0b exp=5a/0", bus.y_data, bus.s0); end
    // Drain 5A and fill from i1 so s0 is 1 before the mid-stream reset.
    bus.i0_valid = 1'b0; bus.y_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.y_data !== 8'h6B || bus.s0 !== 1'b1 || bus.y_valid !== 1'b1) begin bad++; $display("FAIL pre_rst got=%h/%0b/%0b exp=6b/1/1", bus.y_data, bus.s0, bus.y_valid); end
    bus.i1_valid = 1'b0; bus.y_ready = 1'b0; bus.i0_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.y_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_y_valid got=%0b exp=0", bus.y_valid); end
    total++; if (bus.y_data !== 8'h00 || bus.y_last !== 1'b0) begin bad++; $display("FAIL mid_rst_y_data got=%h/%0b exp=00/0", bus.y_data, bus.y_last); end
    total++; if (bus.s0 !== 1'b0) begin bad++; $display("FAIL mid_rst_s0 got=%0b exp=0", bus.s0); end
    total++; if (bus.i0_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%0b exp=0", bus.i0_ready); end
    // Leave prio pointing at i1, then reset: the next contended grant must go to i0.
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i0_data = 8'h7C;
    @(posedge clk); #1;
    total++; if (bus.y_data !== 8'h7C || bus.y_valid !== 1'b1) begin bad++; $display("FAIL pre_rst2 got=%h/%0b exp=7c/1", bus.y_data, bus.y_valid); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i0_data = 8'h7D; bus.i1_data = 8'h6E; bus.i1_valid = 1'b1; bus.y_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.y_data !== 8'h7D || bus.s0 !== 1'b0) begin bad++; $display("FAIL prio_rst got=%h/%0b exp=7d/0", bus.y_data, bus.s0); end
  endtask

  task automatic test_alternate();
    logic [7:0] exp_d [4];
    logic       exp_s [4];
    logic       a0, a1;
    exp_d = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    bus.i0_data = 8'hA0; bus.i0_valid = 1'b1;
    bus.i1_data = 8'hB0; bus.i1_valid = 1'b1;
    bus.y_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a0 = bus.i0_valid & bus.i0_ready;
      a1 = bus.i1_valid & bus.i1_ready;
      total++; if ((a0 ^ a1) !== 1'b1) begin bad++; $display("FAIL alt_one_accept k=%0d got=%0b%0b exp=one", k, a0, a1); end
      @(posedge clk); #1;
      total++; if (bus.y_valid !== 1'b1 || bus.y_data !== exp_d[k] || bus.s0 !== exp_s[k]) begin
        bad++; $display("FAIL alt_beat k=%0d got=%h/%0b/%0b exp=%h/%0b/1", k, bus.y_data, bus.s0, bus.y_valid, exp_d[k], exp_s[k]);
      end
      if (a0) bus.i0_data = bus.i0_data + 8'h01;
      if (a1) bus.i1_data = bus.i1_data + 8'h01;
    end
  endtask

  task automatic test_single_source();
    do_reset();
    bus.i1_data = 8'h11; bus.i1_valid = 1'b1; bus.y_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (bus.i1_ready !== 1'b1) begin bad++; $display("FAIL single_ready k=%0d got=%0b exp=1", k, bus.i1_ready); end
      @(posedge clk); #1;
      total++; if (bus.y_data !== 8'h11 + 8'(k) || bus.s0 !== 1'b1 || bus.y_valid !== 1'b1) begin
        bad++; $display("FAIL single_beat k=%0d got=%h/%0b exp=%h/1", k, bus.y_data, bus.s0, 8'h11 + 8'(k));
      end
      bus.i1_data = bus.i1_data + 8'h01;
    end
    bus.i0_data = 8'h21; bus.i0_valid = 1'b1; bus.i1_data = 8'h31;
    @(posedge clk); #1;
    total++; if (bus.y_data !== 8'h21 || bus.s0 !== 1'b0) begin bad++; $display("FAIL single_prio got=%h/%0b exp=21/0", bus.y_data, bus.s0); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.i0_data = 8'hC0; bus.i0_valid = 1'b1;
    bus.i1_data = 8'hD0; bus.i1_valid = 1'b1;
    @(posedge clk); #1;
    bus.i0_data = 8'hC1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (bus.i0_ready !== 1'b0 || bus.i1_ready !== 1'b0) begin bad++; $display("FAIL bp_ready k=%0d got=%0b%0b exp=00", k, bus.i0_ready, bus.i1_ready); end
      @(posedge clk); #1;
      total++; if (bus.y_data !== 8'hC0 || bus.y_valid !== 1'b1 || bus.s0 !== 1'b0) begin bad++; $display("FAIL bp_hold k=%0d got=%h/%0b exp=c0/1", k, bus.y_data, bus.y_valid); end
    end
    bus.y_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.i1_ready !== 1'b1 || bus.i0_ready !== 1'b0) begin bad++; $display("FAIL bp_release_ready got=%0b%0b exp=01", bus.i0_ready, bus.i1_ready); end
    @(posedge clk); #1;
    total++; if (bus.y_data !== 8'hD0 || bus.s0 !== 1'b1) begin bad++; $display("FAIL bp_release_beat got=%h/%0b exp=d0/1", bus.y_data, bus.s0); end
  endtask

  task automatic test_packet();
    logic [7:0] pkt_d [3];
    logic       pkt_l [3];
    logic [7:0] exp_d [5];
    logic       exp_s [5];
    logic       exp_l [5];
    int         p0;
    logic       a0, a1;
    pkt_d = '{8'hE0, 8'hE1, 8'hE2};
    pkt_l = '{1'b0, 1'b0, 1'b1};
`ifdef PACKET_LOCK_EN
    exp_d = '{8'hE0, 8'hE1, 8'hE2, 8'hF0, 8'hF1};
    exp_s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    exp_d = '{8'hE0, 8'hF0, 8'hE1, 8'hF1, 8'hE2};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
    do_reset();
    p0 = 0;
    bus.i1_data = 8'hF0; bus.i1_last = 1'b1; bus.i1_valid = 1'b1;
    bus.y_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.i0_valid = (p0 < 3);
      bus.i0_data  = (p0 < 3) ? pkt_d[p0] : 8'h00;
      bus.i0_last  = (p0 < 3) ? pkt_l[p0] : 1'b1;
      @(negedge clk);
      a0 = bus.i0_valid & bus.i0_ready;
      a1 = bus.i1_valid & bus.i1_ready;
      @(posedge clk); #1;
      total++; if (bus.y_data !== exp_d[k] || bus.s0 !== exp_s[k] || bus.y_last !== exp_l[k]) begin
        bad++; $display("FAIL pkt_beat k=%0d got=%h/%0b/%0b exp=%h/%0b/%0b", k, bus.y_data, bus.s0, bus.y_last, exp_d[k], exp_s[k], exp_l[k]);
      end
      if (a0) p0++;
      if (a1) bus.i1_data = bus.i1_data + 8'h01;
    end
  endtask

  task automatic test_drain_fill();
    do_reset();
    bus.i0_data = 8'h40; bus.i0_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.y_data !== 8'h40 || bus.y_valid !== 1'b1) begin bad++; $display("FAIL df_first got=%h/%0b exp=40/1", bus.y_data, bus.y_valid); end
    bus.i0_data = 8'h41; bus.y_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.i0_ready !== 1'b1) begin bad++; $display("FAIL df_ready got=%0b exp=1", bus.i0_ready); end
    @(posedge clk); #1;
    total++; if (bus.y_data !== 8'h41 || bus.y_valid !== 1'b1) begin bad++; $display("FAIL df_refill got=%h/%0b exp=41/1", bus.y_data, bus.y_valid); end
    bus.i0_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.y_valid !== 1'b0 || bus.y_data !== 8'h41 || bus.s0 !== 1'b0) begin bad++; $display("FAIL df_drain got=%h/%0b exp=41/0", bus.y_data, bus.y_valid); end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single_source();
    test_backpressure();
    test_packet();
    test_drain_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
